// File: rtl/slow_fast_pkg.sv
// rtl/slow_fast_pkg.sv - shared defaults and width helper for the slow-to-fast buffer
package slow_fast_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DIV   = 4;
    localparam int DEF_DEPTH = 4;

    // Occupancy runs 0..DEPTH inclusive, so it needs one bit beyond the pointer width.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/en_div.sv
// rtl/en_div.sv - phase counter producing the one-cycle slow-side sample strobe
module en_div
    import slow_fast_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic fast_clk,
    input  logic rst_n,
    output logic slow_en
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] phase_q;
    logic [CW-1:0] phase_d;

    always_comb begin
        phase_d = phase_q + CW'(1);
        if (phase_q == LAST) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Pure decode of the register, so the strobe carries no input-to-output path.
    assign slow_en = (phase_q == LAST);

endmodule

// File: rtl/slow_to_fast_buf.sv
// rtl/slow_to_fast_buf.sv - first-word-fall-through buffer from a slow strobe domain to fast_clk
module slow_to_fast_buf
    import slow_fast_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIV   = DEF_DIV,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                          fast_clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          slow_en,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [level_w(DEPTH)-1:0]     level,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic attempt;
    logic push;
    logic pop;
    logic drop;

    en_div #(.DIV(DIV)) u_en_div (
        .fast_clk (fast_clk),
        .rst_n    (rst_n),
        .slow_en  (slow_en)
    );

    assign out_valid = (level_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;
    assign overflow  = ovf_q;

    // A full buffer still accepts a word when the head leaves in the same cycle.
    assign attempt = slow_en & in_valid;
    assign pop     = out_valid & out_ready;
    assign push    = attempt & ((level_q < FULL) | pop);
    assign drop    = attempt & ~push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag raised.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge fast_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge fast_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_slow_to_fast_buf.sv
// tb/tb_slow_to_fast_buf.sv - directed self-checking bench for slow_to_fast_buf
module tb_slow_to_fast_buf;

    logic       fast_clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] in_data;
    logic       slow_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [2:0] level;
    logic       overflow;
    logic       clr_ovf;

    int checks;
    int failures;

    slow_to_fast_buf dut (
        .fast_clk  (fast_clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .slow_en   (slow_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge fast_clk);
        #1;
    endtask

    // Leaves the bench inside a cycle where slow_en is high.
    task automatic wait_en();
        for (int i = 0; i < 8; i++) begin
            if (slow_en === 1'b1) break;
            step();
        end
        check("wait_en", {31'd0, slow_en}, 32'd1);
    endtask

    task automatic push_word(input logic [3:0] d);
        in_data  = d;
        in_valid = 1'b1;
        wait_en();
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Reset state and idle strobe pattern.
        step();
        step();
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_slow_en", {31'd0, slow_en}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            check($sformatf("idle_en_c%0d", c), {31'd0, slow_en}, ((c % 4) == 3) ? 32'd1 : 32'd0);
            check($sformatf("idle_valid_c%0d", c), {31'd0, out_valid}, 32'd0);
            check($sformatf("idle_level_c%0d", c), {29'd0, level}, 32'd0);
            step();
        end

        // Streaming pass-through with one-cycle residency.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        wait_en();
        step();
        in_data = 4'h5;
        check("pass_a_valid", {31'd0, out_valid}, 32'd1);
        check("pass_a_data", {28'd0, out_data}, 32'hA);
        step();
        check("pass_a_gone", {31'd0, out_valid}, 32'd0);
        wait_en();
        step();
        in_valid = 1'b0;
        check("pass_5_valid", {31'd0, out_valid}, 32'd1);
        check("pass_5_data", {28'd0, out_data}, 32'h5);
        step();
        check("pass_5_gone", {31'd0, out_valid}, 32'd0);

        // Fill past capacity; the fifth word is dropped.
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_word(4'(i));
            check($sformatf("fill_level_%0d", i), {29'd0, level}, (i > 4) ? 32'd4 : 32'(i));
            check($sformatf("fill_ovf_%0d", i), {31'd0, overflow}, (i == 5) ? 32'd1 : 32'd0);
        end
        out_ready = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            check($sformatf("drain_valid_%0d", j), {31'd0, out_valid}, 32'd1);
            check($sformatf("drain_data_%0d", j), {28'd0, out_data}, 32'(j));
            step();
        end
        check("drain_empty", {31'd0, out_valid}, 32'd0);
        check("drain_level", {29'd0, level}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);

        // Full buffer with simultaneous push and pop.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_word(4'(i));
        check("full_level", {29'd0, level}, 32'd4);
        in_data  = 4'hF;
        in_valid = 1'b1;
        wait_en();
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("pushpop_level", {29'd0, level}, 32'd4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("pp_data_%0d", j), {28'd0, out_data}, (j == 3) ? 32'hF : 32'(j + 2));
            step();
        end
        check("pp_empty", {31'd0, out_valid}, 32'd0);

        // Set beats clear in the same cycle; clear alone then takes effect.
        out_ready = 1'b0;
        clr_ovf   = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 4; i++) push_word(4'(8 + i));
        push_word(4'h7);
        check("ovf_set_again", {31'd0, overflow}, 32'd1);
        in_data  = 4'h6;
        in_valid = 1'b1;
        wait_en();
        clr_ovf = 1'b1;
        step();
        in_valid = 1'b0;
        check("ovf_set_wins", {31'd0, overflow}, 32'd1);
        step();
        clr_ovf = 1'b0;
        check("ovf_clr_alone", {31'd0, overflow}, 32'd0);
        check("drop_level", {29'd0, level}, 32'd4);
        check("drop_head", {28'd0, out_data}, 32'h8);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pre_rst_level", {29'd0, level}, 32'd3);
        check("pre_rst_head", {28'd0, out_data}, 32'h9);

        // Mid-operation reset discards contents and restarts the phase.
        clr_ovf = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("mid_rst_level", {29'd0, level}, 32'd0);
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        check("mid_rst_en", {31'd0, slow_en}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("post_rst_en_c%0d", c), {31'd0, slow_en}, (c == 3) ? 32'd1 : 32'd0);
            step();
        end
        check("post_rst_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/slow_to_fast_buf.md
SLOW_TO_FAST_BUF -- requirements
Module: slow_to_fast_buf

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the data word width in bits.
REQ-002 Parameter DIV, default 4 (range 2..16), SHALL set the slow-rate enable period in fast_clk cycles.
REQ-003 Parameter DEPTH, default 4 (power of 2, 2..16), SHALL set the number of buffer entries.
REQ-004 fast_clk  in  1  sole clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  slow-side word present; qualified only by slow_en.
REQ-007 in_data  in  WIDTH  slow-side word.
REQ-008 slow_en  out  1  one-cycle strobe, once every DIV cycles; marks the slow-side sample point.
REQ-009 out_valid  out  1  buffer head word available.
REQ-010 out_ready  in  1  fast-side consumer accepts the head word.
REQ-011 out_data  out  WIDTH  buffer head word; don't-care when out_valid=0.
REQ-012 level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 overflow  out  1  sticky flag: a slow-side word was dropped.
REQ-014 clr_ovf  in  1  synchronous clear of overflow.

Function
REQ-015 Phase counter SHALL count 0..DIV-1 every cycle and wrap from DIV-1 to 0.
REQ-016 slow_en SHALL be 1 exactly when the phase counter equals DIV-1, decoded from the registered count without combinational input paths.
REQ-017 Push SHALL occur when slow_en=1 and in_valid=1 and (level<DEPTH or pop occurs in the same cycle).
REQ-018 in_valid with slow_en=0 SHALL be ignored, with no push and no flag change.
REQ-019 Pop SHALL occur when out_valid=1 and out_ready=1.
REQ-020 Buffer SHALL be first-word-fall-through: a word pushed at edge k SHALL appear on out_data with out_valid=1 after edge k when the buffer was empty (one-cycle latency).
REQ-021 out_valid SHALL equal (level != 0).
REQ-022 Words SHALL leave in arrival order, unmodified.
REQ-023 Simultaneous push and pop SHALL leave level unchanged, including at level=DEPTH and level=0.
  - At level=0, push and pop cannot coincide, since out_valid=0.
REQ-024 Push attempt at level=DEPTH without a same-cycle pop SHALL drop the word, leave the contents intact, and set overflow at the next edge.
REQ-025 overflow SHALL stay 1 until clr_ovf=1.
  - If set and clear coincide, set wins.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 level SHALL update at the same edge as the push/pop that changes it.

Reset
REQ-028 While rst_n=0: phase counter=0, slow_en=0, level=0, out_valid=0, overflow=0, and pointers=0.
  - Buffer contents need no reset.
REQ-029 After rst_n deasserts, the first slow_en SHALL occur in the DIV-th cycle (phase DIV-1).
REQ-030 Reset asserted mid-operation SHALL discard all buffered words immediately, with no pop and no further output.

Structure
REQ-031 Package slow_fast_pkg SHALL hold the defaults DEF_WIDTH=4, DEF_DIV=4 and DEF_DEPTH=4, and the function computing level width.
REQ-032 Sub-module en_div SHALL contain the phase counter and slow_en decode (ports fast_clk, rst_n, slow_en).
  - The buffer SHALL be implemented in slow_to_fast_buf.

Verification
REQ-033 Reset then idle 12 cycles -> slow_en high in cycles 3, 7 and 11 only; out_valid=0; level=0.
REQ-034 in_valid=1 constantly, in_data=4'hA then 4'h5 on successive strobes, out_ready=1 -> out_data A then 5, each with out_valid for exactly 1 cycle after its strobe edge.
REQ-035 out_ready=0, push 4'h1,2,3,4,5 on five strobes -> level reaches 4; 5 is dropped; overflow=1. Then out_ready=1 -> out_data 1,2,3,4, then out_valid=0.
REQ-036 Buffer full and out_ready=1 on a strobe with in_data=4'hF -> level stays 4; F is accepted and output after the 3 older words.
REQ-037 overflow=1 with clr_ovf=1 in the same cycle as a new drop -> overflow stays 1; clr_ovf alone next cycle -> overflow=0.
REQ-038 rst_n pulsed low with level=3 -> level=0, out_valid=0 and overflow=0 during reset; the next slow_en comes DIV cycles after release.
